uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx serialiser between NUM_REQ byte-stream requesters. Round-robin grant,

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Purpose  : Shared types and helpers for the UART TX arbiter: the
//             arbiter state encoding, the grant-index width helper and the
//             default tag base byte.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    // ST_TAG is only reachable when the tag feature is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'h30;

    // Grant-index width; never below one bit so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Scans the request vector
//             starting one above the previous winner, wrapping around, and
//             returns the first requester found.
//  Ports    : req    in  N       request vector
//             last   in  W       index of the previous winner
//             winner out W       selected index (0 when nothing requests)
//             any    out 1       at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        // k = N wraps back to 'last' itself, so the previous holder is
        // picked again only when it is the sole requester.
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                winner = W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares a single uart_tx serialiser between NUM_REQ byte-stream
//             requesters. Round-robin grant held for a whole message (until
//             the req_last byte) or until an idle timeout forces release.
//             Optional feature macro UART_ARB_TAG_EN: each grant first sends
//             the tag byte TAG_BASE + grant index ahead of the payload.
//  Ports    : clk, reset (sync, active-high)
//             req_valid/req_data/req_last in, req_ready out (per requester)
//             tx_ready in, tx_data/tx_strobe out (to uart_tx)
//             grant_valid, grant_idx, timeout out (status)
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT,
    localparam int        IDX_W    = idx_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_strobe,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout
);

    localparam int               C_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_tx_data;
    logic                 r_tx_strobe;
    logic                 r_grant_valid;
    logic                 r_timeout;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_last_grant;
    logic [C_CNT_W-1:0]   r_cnt;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_any;
    logic [7:0]           w_bytes [NUM_REQ];
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_accept;
    logic                 w_expire;
    logic                 w_tag_fire;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = req_data[8*gi +: 8];
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .req    (req_valid),
        .last   (r_last_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_sel_valid = req_valid[r_grant_idx];
    assign w_sel_last  = req_last[r_grant_idx];

    // uart_tx drops ready only the cycle after a strobe, so the strobe cycle
    // itself must be masked to avoid handing it two bytes back-to-back.
    assign w_accept = (r_state == ST_SEND) && tx_ready && !r_tx_strobe && w_sel_valid;
    assign w_expire = (r_state == ST_SEND) && tx_ready && !w_accept && (r_cnt == C_CNT_LAST);

`ifdef UART_ARB_TAG_EN
    assign w_tag_fire = (r_state == ST_TAG) && tx_ready && !r_tx_strobe;
`else
    assign w_tag_fire = 1'b0;
    logic [7:0] w_unused_tag_base;
    assign w_unused_tag_base = TAG_BASE;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
`ifdef UART_ARB_TAG_EN
                    w_state_nxt = ST_TAG;
`else
                    w_state_nxt = ST_SEND;
`endif
                end
            end
            ST_TAG: begin
                if (w_tag_fire) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if ((w_accept && w_sel_last) || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: only the grant holder sees ready, and only on accept.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[r_grant_idx] = 1'b1;
        end
    end

    // Grant, tx byte register and idle-timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_data     <= 8'h00;
            r_tx_strobe   <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_timeout     <= 1'b0;
            r_last_grant  <= C_IDX_LAST;
            r_cnt         <= '0;
        end else begin
            r_tx_strobe <= 1'b0;
            r_timeout   <= w_expire;

            if ((r_state == ST_IDLE) && w_any) begin
                r_grant_idx   <= w_winner;
                r_grant_valid <= 1'b1;
            end

`ifdef UART_ARB_TAG_EN
            if (w_tag_fire) begin
                r_tx_data   <= TAG_BASE + 8'(r_grant_idx);
                r_tx_strobe <= 1'b1;
            end
`endif

            if (w_accept) begin
                r_tx_data   <= w_bytes[r_grant_idx];
                r_tx_strobe <= 1'b1;
                if (w_sel_last) begin
                    r_last_grant  <= r_grant_idx;
                    r_grant_valid <= 1'b0;
                end
            end

            // A stalled holder loses the grant; its byte already handed to
            // uart_tx still finishes on the line.
            if (w_expire) begin
                r_last_grant  <= r_grant_idx;
                r_grant_valid <= 1'b0;
            end

            if ((r_state != ST_SEND) || w_accept || !tx_ready || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_strobe   = r_tx_strobe;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter. Models uart_tx as
//             ready dropping for 10 bit-times (4 clocks each) after a strobe,
//             and models requesters as per-port byte queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int BUSY = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic        timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    // uart_tx model: ready falls the cycle after the strobe, for BUSY clocks
    int busy;
    assign tx_ready = (busy == 0);
    always @(posedge clk) begin
        if (reset)          busy <= 0;
        else if (tx_strobe) busy <= BUSY;
        else if (busy != 0) busy <= busy - 1;
    end

    logic [8:0] q [4][$];
    int         acc_g [$];
    logic [7:0] acc_b [$];
    logic [7:0] pay_log [$];
    logic [7:0] all_log [$];

    int   total, bad, ncyc, to_cnt, to_at, acc_at, rule_viol, ready_viol;
    logic prev_strobe;

    typedef struct {
        logic [7:0] msg [8];   // requester i, slot s at index 2*i+s; 0 = empty
        int         n;
        int         g   [5];
        logic [7:0] b   [5];
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_tag(input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
        return (b >= 8'h30) && (b <= 8'h33);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cycle();
        logic [3:0] rdy;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        ncyc++;
        if (tx_strobe) begin
            all_log.push_back(tx_data);
            if (!is_tag(tx_data)) pay_log.push_back(tx_data);
            if (prev_strobe || !tx_ready) rule_viol++;
        end
        prev_strobe = tx_strobe;
        if (timeout) begin
            to_cnt++;
            to_at = ncyc;
        end
        rdy = req_ready;
        if ((rdy != 4'b0) && (!grant_valid || (rdy != (4'b0001 << grant_idx)))) ready_viol++;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                acc_g.push_back(i);
                acc_b.push_back(q[i][0][7:0]);
                acc_at = ncyc;
                void'(q[i].pop_front());
            end
        end
        #1;
    endtask

    function automatic bit idle();
        bit e;
        e = 1'b1;
        for (int i = 0; i < 4; i++) if (q[i].size() != 0) e = 1'b0;
        return e && !grant_valid && (busy == 0) && !tx_strobe;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!idle() && (n < 3000)) begin
            cycle();
            n++;
        end
        check(name, idle(), 1);
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        while ((acc_g.size() == 0) && (n < 1000)) begin
            cycle();
            n++;
        end
        check(name, (acc_g.size() != 0), 1);
    endtask

    task automatic clear_logs();
        acc_g.delete();
        acc_b.delete();
        pay_log.delete();
        all_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"}, tx_strobe, 0);
        check({tag, "_data"},   tx_data, 0);
        check({tag, "_ready"},  req_ready, 0);
        check({tag, "_gvalid"}, grant_valid, 0);
        check({tag, "_gidx"},   grant_idx, 0);
        check({tag, "_tmo"},    timeout, 0);
    endtask

    task automatic check_seq(input string tag, input int n, input int g [5], input logic [7:0] b [5]);
        check({tag, "_count"}, acc_g.size(), n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_grant%0d", tag, j), (j < acc_g.size()) ? acc_g[j] : -1, g[j]);
            check($sformatf("%s_byte%0d", tag, j), (j < acc_b.size()) ? acc_b[j] : 8'hxx, b[j]);
            check($sformatf("%s_txd%0d", tag, j), (j < pay_log.size()) ? pay_log[j] : 8'hxx, b[j]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; ncyc = 0; to_cnt = 0; to_at = 0; acc_at = 0;
        rule_viol = 0; ready_viol = 0; prev_strobe = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;

        vt[0].msg = '{8'hA0, 8'hA4, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA3, 8'h00};
        vt[0].n = 5; vt[0].g = '{0, 1, 2, 3, 0};
        vt[0].b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        vt[1].msg = '{8'h00, 8'h00, 8'hB1, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00};
        vt[1].n = 2; vt[1].g = '{1, 3, 0, 0, 0};
        vt[1].b = '{8'hB1, 8'hB3, 8'h00, 8'h00, 8'h00};
        vt[2].msg = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'hC2, 8'h00, 8'h00, 8'h00};
        vt[2].n = 2; vt[2].g = '{0, 2, 0, 0, 0};
        vt[2].b = '{8'hC0, 8'hC2, 8'h00, 8'h00, 8'h00};
        vt[3].msg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00};
        vt[3].n = 1; vt[3].g = '{2, 0, 0, 0, 0};
        vt[3].b = '{8'hD2, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4].msg = '{8'h00, 8'h00, 8'hE1, 8'h00, 8'hE2, 8'h00, 8'hE3, 8'h00};
        vt[4].n = 3; vt[4].g = '{3, 1, 2, 0, 0};
        vt[4].b = '{8'hE3, 8'hE1, 8'hE2, 8'h00, 8'h00};

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Single 3-byte message from requester 0
        clear_logs();
        q[0].push_back({1'b0, 8'h41});
        q[0].push_back({1'b0, 8'h42});
        q[0].push_back({1'b1, 8'h43});
        drain("t1_drain");
        check_seq("t1", 3, '{0, 0, 0, 0, 0}, '{8'h41, 8'h42, 8'h43, 8'h00, 8'h00});
        check("t1_gvalid_after", grant_valid, 0);

        // Round-robin table; starts from reset so index 0 wins first
        do_reset();
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            for (int k = 0; k < 8; k++) begin
                if (vt[v].msg[k] != 8'h00) q[k/2].push_back({1'b1, vt[v].msg[k]});
            end
            drain($sformatf("v%0d_drain", v));
            check_seq($sformatf("v%0d", v), vt[v].n, vt[v].g, vt[v].b);
        end

        // Requester 2 arrives mid-message of requester 0 and must wait
        clear_logs();
        q[0].push_back({1'b0, 8'h50});
        q[0].push_back({1'b0, 8'h51});
        q[0].push_back({1'b1, 8'h52});
        wait_accept("t3_first");
        q[2].push_back({1'b1, 8'h62});
        drain("t3_drain");
        check_seq("t3", 4, '{0, 0, 0, 2, 0}, '{8'h50, 8'h51, 8'h52, 8'h62, 8'h00});

        // Requester 1 stalls without a last byte: forced release, then 3
        clear_logs();
        to_cnt = 0;
        q[1].push_back({1'b0, 8'h71});
        wait_accept("t4_first");
        q[3].push_back({1'b1, 8'h73});
        begin
            int a;
            a = acc_at;
            drain("t4_drain");
            check("t4_tmo_pulses", to_cnt, 1);
            check("t4_tmo_delay", to_at - a, 2 + BUSY + TMO);
        end
        check_seq("t4", 2, '{1, 3, 0, 0, 0}, '{8'h71, 8'h73, 8'h00, 8'h00, 8'h00});

        // Grant 2 with a single byte; tag precedes it when compiled in
        clear_logs();
        q[2].push_back({1'b1, 8'h55});
        drain("t6_drain");
`ifdef UART_ARB_TAG_EN
        check("t6_nstrobes", all_log.size(), 2);
        check("t6_tag", (all_log.size() > 0) ? all_log[0] : 8'hxx, 8'h32);
        check("t6_payload", (all_log.size() > 1) ? all_log[1] : 8'hxx, 8'h55);
`else
        check("t6_nstrobes", all_log.size(), 1);
        check("t6_payload", (all_log.size() > 0) ? all_log[0] : 8'hxx, 8'h55);
`endif

        // Reset mid-message
        clear_logs();
        q[0].push_back({1'b0, 8'h80});
        q[0].push_back({1'b0, 8'h81});
        q[0].push_back({1'b1, 8'h82});
        wait_accept("t6_mid_first");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        cycle();
        check_reset_outputs("midrst");
        reset = 1'b0;
        clear_logs();
        repeat (60) cycle();
        check("midrst_no_strobe", all_log.size(), 0);
        check("midrst_no_accept", acc_g.size(), 0);

        // Strobe and ready rules over the whole run
        check("strobe_rules", rule_viol, 0);
        check("ready_rules", ready_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
